// File: rtl/score_keeper_if.sv
// score_keeper_if: row-scanner inputs and score/status outputs of score_keeper.
// Handshake: the scanner presents one evaluated row per cycle with scan_valid
// high; get_score and sweep_last are meaningful only while scan_valid is high.
// There is no back-pressure: every valid row is consumed in its own cycle.
interface score_keeper_if;
    logic        scan_valid;
    logic        get_score;
    logic        sweep_last;
    logic [23:0] score_bcd;
    logic [9:0]  lines;
    logic [3:0]  level;
    logic [3:0]  combo;
    logic        award_pulse;
    logic        busy;
    logic [1:0]  dbg_state;

    modport master (
        output scan_valid, get_score, sweep_last,
        input  score_bcd, lines, level, combo, award_pulse, busy, dbg_state
    );

    modport slave (
        input  scan_valid, get_score, sweep_last,
        output score_bcd, lines, level, combo, award_pulse, busy, dbg_state
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: counts complete rows per board sweep, accumulates cleared lines
// and level, and adds the line-clear award to a 6-digit BCD score, one BCD add
// per cycle (base award repeated level+1 times). A one-deep request queue holds
// a sweep that ends while an award is still running.
// Optional feature macro: SCORE_COMBO_EN (combo counter plus 50 per combo unit).
module score_keeper (
    input  logic          clk,
    input  logic          rst,
    score_keeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, AWARD = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q;
    logic [2:0]  sweep_cnt_q;
    logic [23:0] score_q;
    logic [9:0]  lines_q;
    logic [3:0]  level_q;
    logic        pend_q;
    logic [2:0]  pend_cnt_q;
    logic [3:0]  pend_combo_q;
    logic [23:0] base_q;
    logic [4:0]  mult_left_q;
    logic [3:0]  combo_left_q;
    logic        busy_q;
    logic        pulse_q;

    logic        row_hit;
    logic        sweep_end;
    logic [2:0]  cnt_inc;
    logic        req_now;
    logic [10:0] lines_sum;
    logic [9:0]  lines_d;
    logic [9:0]  lvl_div;
    logic [3:0]  level_d;
    logic [3:0]  merged_sum;
    logic [2:0]  merged_cnt;
    logic [5:0]  remaining;
    logic [3:0]  combo_new;

    function automatic logic [23:0] base_of(input logic [2:0] cnt);
        case (cnt)
            3'd1:    base_of = 24'h000100;
            3'd2:    base_of = 24'h000300;
            3'd3:    base_of = 24'h000500;
            default: base_of = 24'h000800;
        endcase
    endfunction

    // Digit-serial-free 6-digit BCD add; a carry out of the top digit pins 999999.
    function automatic logic [23:0] bcd_add(input logic [23:0] a, input logic [23:0] b);
        logic [4:0]  s;
        logic        c;
        logic [23:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        if (c) r = 24'h999999;
        return r;
    endfunction

    // Sweep bookkeeping: running row count, final count, line and level targets.
    always_comb begin
        row_hit    = bus.scan_valid & bus.get_score;
        sweep_end  = bus.scan_valid & bus.sweep_last;
        cnt_inc    = (sweep_cnt_q == 3'd4) ? 3'd4 : sweep_cnt_q + {2'b0, row_hit};
        req_now    = sweep_end & (cnt_inc != 3'd0);
        lines_sum  = {1'b0, lines_q} + {8'b0, cnt_inc};
        lines_d    = (lines_sum > 11'd999) ? 10'd999 : lines_sum[9:0];
        lvl_div    = lines_q / 10'd10;
        level_d    = (lvl_div > 10'd15) ? 4'd15 : lvl_div[3:0];
        merged_sum = {1'b0, pend_cnt_q} + {1'b0, cnt_inc};
        merged_cnt = (merged_sum > 4'd4) ? 3'd4 : merged_sum[2:0];
        remaining  = {1'b0, mult_left_q} + {2'b0, combo_left_q};
    end

`ifdef SCORE_COMBO_EN
    logic [3:0] combo_q;
    logic       streak_q;

    // Combo value this sweep would carry if it scores: 0 on the first scoring sweep.
    always_comb begin
        combo_new = 4'd0;
        if (streak_q) combo_new = (combo_q == 4'd15) ? 4'd15 : combo_q + 4'd1;
    end

    // Combo streak tracking, updated at every sweep end.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_q  <= 4'd0;
            streak_q <= 1'b0;
        end else if (sweep_end) begin
            if (cnt_inc != 3'd0) begin
                combo_q  <= combo_new;
                streak_q <= 1'b1;
            end else begin
                combo_q  <= 4'd0;
                streak_q <= 1'b0;
            end
        end
    end

    assign bus.combo = combo_q;
`else
    assign combo_new = 4'd0;
    assign bus.combo = 4'd0;
`endif

    // Row counter, cleared-line total and level (level trails lines by one cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt_q <= 3'd0;
            lines_q     <= 10'd0;
            level_q     <= 4'd0;
        end else begin
            level_q <= level_d;
            if (sweep_end) begin
                sweep_cnt_q <= 3'd0;
                lines_q     <= lines_d;
            end else if (row_hit) begin
                sweep_cnt_q <= cnt_inc;
            end
        end
    end

    // Award FSM with its one-deep request queue and the score accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= 24'd0;
            pend_q       <= 1'b0;
            pend_cnt_q   <= 3'd0;
            pend_combo_q <= 4'd0;
            base_q       <= 24'd0;
            mult_left_q  <= 5'd0;
            combo_left_q <= 4'd0;
            busy_q       <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (pend_q) begin
                        // Serve the queued request; a sweep ending now takes its slot.
                        state_q      <= AWARD;
                        busy_q       <= 1'b1;
                        base_q       <= base_of(pend_cnt_q);
                        mult_left_q  <= {1'b0, level_q} + 5'd1;
                        combo_left_q <= pend_combo_q;
                        pend_q       <= req_now;
                        if (req_now) begin
                            pend_cnt_q   <= cnt_inc;
                            pend_combo_q <= combo_new;
                        end
                    end else if (req_now) begin
                        state_q      <= AWARD;
                        busy_q       <= 1'b1;
                        base_q       <= base_of(cnt_inc);
                        mult_left_q  <= {1'b0, level_q} + 5'd1;
                        combo_left_q <= combo_new;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                AWARD: begin
                    if (mult_left_q != 5'd0) begin
                        score_q     <= bcd_add(score_q, base_q);
                        mult_left_q <= mult_left_q - 5'd1;
                    end else begin
                        score_q      <= bcd_add(score_q, 24'h000050);
                        combo_left_q <= combo_left_q - 4'd1;
                    end
                    if (remaining == 6'd1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        pulse_q <= 1'b1;
                    end
                    if (req_now) begin
                        pend_q       <= 1'b1;
                        pend_cnt_q   <= pend_q ? merged_cnt : cnt_inc;
                        pend_combo_q <= combo_new;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.score_bcd   = score_q;
    assign bus.lines       = lines_q;
    assign bus.level       = level_q;
    assign bus.award_pulse = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed test of score_keeper. Inputs change on the falling
// edge and are consumed by the following rising edge; outputs are sampled on
// the falling edge after each consuming edge.
module tb_score_keeper;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_keeper_if sk();

    score_keeper dut (
        .clk (clk),
        .rst (rst),
        .bus (sk)
    );

    int checks    = 0;
    int passes    = 0;
    int busy_acc  = 0;
    int pulse_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle of scanner input; accumulates busy/pulse seen after the edge.
    task automatic step(input logic v, input logic g, input logic l);
        sk.scan_valid = v;
        sk.get_score  = g;
        sk.sweep_last = l;
        @(negedge clk);
        busy_acc  += int'(sk.busy);
        pulse_acc += int'(sk.award_pulse);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Sweep of n rows; mask bit i marks row i complete; last row ends the sweep.
    task automatic sweep(input int n, input logic [31:0] mask);
        for (int i = 0; i < n; i++) step(1'b1, mask[i], i == n - 1);
        sk.scan_valid = 1'b0;
        sk.get_score  = 1'b0;
        sk.sweep_last = 1'b0;
    endtask

    task automatic clr_acc();
        busy_acc  = 0;
        pulse_acc = 0;
    endtask

    function automatic logic [23:0] to_bcd(input int val);
        logic [23:0] r;
        int v;
        v = val;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lines;
        int exp_score;
        int lvl;

        rst = 1'b1;
        sk.scan_valid = 1'b0;
        sk.get_score  = 1'b0;
        sk.sweep_last = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        chk("rst_score", 32'(sk.score_bcd), 32'h0);
        chk("rst_lines", 32'(sk.lines), 32'd0);
        chk("rst_level", 32'(sk.level), 32'd0);
        chk("rst_combo", 32'(sk.combo), 32'd0);
        chk("rst_busy",  32'(sk.busy), 32'd0);
        chk("rst_pulse", 32'(sk.award_pulse), 32'd0);
        chk("rst_state", 32'(sk.dbg_state), 32'd0);

`ifndef SCORE_COMBO_EN
        // Single line on row 19: exact cycle timing of busy and pulse.
        sweep(20, 32'h0008_0000);
        chk("one_busy_e0",  32'(sk.busy), 32'd1);
        chk("one_lines",    32'(sk.lines), 32'd1);
        chk("one_pulse_e0", 32'(sk.award_pulse), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("one_busy_e1",  32'(sk.busy), 32'd0);
        chk("one_pulse_e1", 32'(sk.award_pulse), 32'd1);
        chk("one_score",    32'(sk.score_bcd), 32'h100);
        step(1'b0, 1'b0, 1'b0);
        chk("one_pulse_e2", 32'(sk.award_pulse), 32'd0);
        chk("one_state_e2", 32'(sk.dbg_state), 32'd0);

        // Row inputs without scan_valid are ignored.
        clr_acc();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("novalid_lines", 32'(sk.lines), 32'd1);
        chk("novalid_busy",  32'(busy_acc), 32'd0);

        // Five complete rows saturate at four: base 800 at level 0.
        clr_acc();
        sweep(20, 32'h1F);
        idle(4);
        chk("sat4_lines", 32'(sk.lines), 32'd5);
        chk("sat4_score", 32'(sk.score_bcd), 32'h900);
        chk("sat4_busy",  32'(busy_acc), 32'd1);
        chk("sat4_pulse", 32'(pulse_acc), 32'd1);

        sweep(20, 32'hF);
        idle(4);
        chk("l9_lines", 32'(sk.lines), 32'd9);
        chk("l9_score", 32'(sk.score_bcd), 32'h1700);

        // Lines reach 10: level follows one cycle later.
        sweep(20, 32'h0008_0000);
        chk("l10_lines",     32'(sk.lines), 32'd10);
        chk("l10_level_e0",  32'(sk.level), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("l10_level_e1",  32'(sk.level), 32'd1);
        idle(3);
        chk("l10_score",     32'(sk.score_bcd), 32'h1800);

        clr_acc();
        sweep(4, 32'hF);
        idle(5);
        chk("l14_lines", 32'(sk.lines), 32'd14);
        chk("l14_score", 32'(sk.score_bcd), 32'h3400);
        chk("l14_busy",  32'(busy_acc), 32'd2);

        sweep(4, 32'hF);
        idle(5);
        chk("l18_score", 32'(sk.score_bcd), 32'h5000);

        sweep(2, 32'h3);
        idle(5);
        chk("l20_lines", 32'(sk.lines), 32'd20);
        chk("l20_score", 32'(sk.score_bcd), 32'h5600);
        chk("l20_level", 32'(sk.level), 32'd2);

        // Level 2, four lines: 3 x 800.
        clr_acc();
        sweep(4, 32'hF);
        chk("l24_lines",    32'(sk.lines), 32'd24);
        chk("l24_level_e0", 32'(sk.level), 32'd2);
        idle(6);
        chk("l24_score",    32'(sk.score_bcd), 32'h8000);
        chk("l24_busy",     32'(busy_acc), 32'd3);
        chk("l24_pulse",    32'(pulse_acc), 32'd1);
        chk("l24_level",    32'(sk.level), 32'd2);

        // Sweeps ending during AWARD/DONE: queue, merge, and counting while busy.
        clr_acc();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(14);
        chk("q_busy",  32'(busy_acc), 32'd9);
        chk("q_pulse", 32'(pulse_acc), 32'd3);
        chk("q_lines", 32'(sk.lines), 32'd28);
        chk("q_score", 32'(sk.score_bcd), 32'h9500);
        chk("q_state", 32'(sk.dbg_state), 32'd0);

        // Reset in the middle of an award, with active inputs, abandons it.
        sweep(1, 32'h1);
        chk("rstmid_busy_before", 32'(sk.busy), 32'd1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        sk.scan_valid = 1'b0;
        sk.get_score  = 1'b0;
        sk.sweep_last = 1'b0;
        chk("rstmid_score", 32'(sk.score_bcd), 32'h0);
        chk("rstmid_lines", 32'(sk.lines), 32'd0);
        chk("rstmid_level", 32'(sk.level), 32'd0);
        chk("rstmid_busy",  32'(sk.busy), 32'd0);
        chk("rstmid_state", 32'(sk.dbg_state), 32'd0);
        clr_acc();
        idle(6);
        chk("rstmid_pulse_after", 32'(pulse_acc), 32'd0);
        chk("rstmid_score_after", 32'(sk.score_bcd), 32'h0);

        // Long run of four-line sweeps: score saturates at 999999, lines at 999.
        exp_lines = 0;
        exp_score = 0;
        for (int k = 0; k < 255; k++) begin
            lvl = (exp_lines / 10 > 15) ? 15 : exp_lines / 10;
            clr_acc();
            sweep(4, 32'hF);
            idle(18);
            exp_lines = (exp_lines + 4 > 999) ? 999 : exp_lines + 4;
            exp_score = exp_score + 800 * (lvl + 1);
            if (exp_score > 999999) exp_score = 999999;
            chk($sformatf("sat_score_%0d", k), 32'(sk.score_bcd), 32'(to_bcd(exp_score)));
            chk($sformatf("sat_lines_%0d", k), 32'(sk.lines), 32'(exp_lines));
            chk($sformatf("sat_busy_%0d", k),  32'(busy_acc), 32'(lvl + 1));
            chk($sformatf("sat_pulse_%0d", k), 32'(pulse_acc), 32'd1);
        end
        chk("sat_final_score", 32'(sk.score_bcd), 32'h999999);
        chk("sat_final_lines", 32'(sk.lines), 32'd999);
        chk("sat_final_level", 32'(sk.level), 32'd15);
        chk("combo_tied_zero", 32'(sk.combo), 32'd0);
`else
        // Combo: three scoring sweeps then an empty one.
        clr_acc();
        sweep(1, 32'h1);
        chk("cmb1_combo", 32'(sk.combo), 32'd0);
        idle(4);
        chk("cmb1_score", 32'(sk.score_bcd), 32'h100);
        chk("cmb1_busy",  32'(busy_acc), 32'd1);

        clr_acc();
        sweep(1, 32'h1);
        chk("cmb2_combo", 32'(sk.combo), 32'd1);
        idle(4);
        chk("cmb2_score", 32'(sk.score_bcd), 32'h250);
        chk("cmb2_busy",  32'(busy_acc), 32'd2);
        chk("cmb2_pulse", 32'(pulse_acc), 32'd1);

        clr_acc();
        sweep(1, 32'h1);
        chk("cmb3_combo", 32'(sk.combo), 32'd2);
        idle(5);
        chk("cmb3_score", 32'(sk.score_bcd), 32'h450);
        chk("cmb3_busy",  32'(busy_acc), 32'd3);

        clr_acc();
        sweep(1, 32'h0);
        chk("cmb4_combo", 32'(sk.combo), 32'd0);
        chk("cmb4_lines", 32'(sk.lines), 32'd3);
        idle(3);
        chk("cmb4_score", 32'(sk.score_bcd), 32'h450);
        chk("cmb4_pulse", 32'(pulse_acc), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
